// File: rtl/stopwatch_pkg.sv
// Shared types for the stopwatch: FSM states and the BCD digit type.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        PAUSED,
        RUN,
        ADJUST
    } sw_state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_NINE = 4'd9;

endpackage

// File: rtl/bcd_field_ctr.sv
// Two-digit BCD counter that wraps from MAX to 00; carry pulses on that wrap.
module bcd_field_ctr
    import stopwatch_pkg::*;
#(
    parameter int unsigned MAX = 59
) (
    input  logic sclk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output bcd_t tens,
    output bcd_t ones,
    output logic carry
);

    localparam bcd_t MAX_TENS = bcd_t'(MAX / 10);
    localparam bcd_t MAX_ONES = bcd_t'(MAX % 10);

    bcd_t tens_q, tens_d;
    bcd_t ones_q, ones_d;
    logic at_max;

    assign at_max = (tens_q == MAX_TENS) && (ones_q == MAX_ONES);

    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        carry  = 1'b0;
        // Clear outranks a same-cycle increment, so the increment is simply lost.
        if (clr) begin
            tens_d = '0;
            ones_d = '0;
        end else if (inc) begin
            if (at_max) begin
                tens_d = '0;
                ones_d = '0;
                carry  = 1'b1;
            end else if (ones_q == BCD_NINE) begin
                ones_d = '0;
                tens_d = tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
    end

    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            tens_q <= '0;
            ones_q <= '0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

    assign tens = tens_q;
    assign ones = ones_q;

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS BCD stopwatch with run/pause, clear and manual adjust.
// Optional lap freeze of the displayed digits when STOPWATCH_LAP_EN is defined.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned MIN_MAX = 59,
    parameter int unsigned SEC_MAX = 59
) (
    input  logic sclk,
    input  logic rst,
    input  logic tick_1hz,
    input  logic tick_2hz,
    input  logic pause_p,
    input  logic clear_p,
    input  logic adj,
    input  logic sel,
`ifdef STOPWATCH_LAP_EN
    input  logic lap_p,
    output logic lap_hold,
`endif
    output bcd_t min_t,
    output bcd_t min_o,
    output bcd_t sec_t,
    output bcd_t sec_o,
    output logic running,
    output logic blink,
    output logic wrap_p
);

    sw_state_t state_q, state_d;
    logic      blink_q, blink_d;
    logic      wrap_q, wrap_d;

    logic run_tick, adj_tick;
    logic sec_inc, min_inc;
    logic sec_carry, min_carry;
    bcd_t live_min_t, live_min_o, live_sec_t, live_sec_o;

    always_comb begin
        state_d = state_q;
        if (adj) begin
            state_d = ADJUST;
        end else if (state_q == ADJUST) begin
            state_d = PAUSED;
        end else if (pause_p) begin
            state_d = (state_q == RUN) ? PAUSED : RUN;
        end
    end

    // A tick only counts when the mode it belongs to is still selected this cycle.
    assign run_tick = (state_q == RUN) && !adj && tick_1hz;
    assign adj_tick = (state_q == ADJUST) && adj && tick_2hz;

    assign sec_inc = run_tick || (adj_tick && !sel);
    assign min_inc = (run_tick && sec_carry) || (adj_tick && sel);

    always_comb begin
        blink_d = blink_q;
        if (state_d != ADJUST) begin
            blink_d = 1'b0;
        end else if (adj_tick) begin
            blink_d = !blink_q;
        end
        wrap_d = run_tick && min_carry;
    end

    bcd_field_ctr #(.MAX(SEC_MAX)) u_sec (
        .sclk  (sclk),
        .rst   (rst),
        .inc   (sec_inc),
        .clr   (clear_p),
        .tens  (live_sec_t),
        .ones  (live_sec_o),
        .carry (sec_carry)
    );

    bcd_field_ctr #(.MAX(MIN_MAX)) u_min (
        .sclk  (sclk),
        .rst   (rst),
        .inc   (min_inc),
        .clr   (clear_p),
        .tens  (live_min_t),
        .ones  (live_min_o),
        .carry (min_carry)
    );

    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            state_q <= PAUSED;
            blink_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            blink_q <= blink_d;
            wrap_q  <= wrap_d;
        end
    end

    assign running = (state_q == RUN);
    assign blink   = blink_q;
    assign wrap_p  = wrap_q;

`ifdef STOPWATCH_LAP_EN
    logic        lap_hold_q, lap_hold_d;
    logic [15:0] snap_q, snap_d;
    logic [15:0] live_time;

    assign live_time = {live_min_t, live_min_o, live_sec_t, live_sec_o};

    // The snapshot is the time shown at the moment of lap_p; counting continues underneath.
    always_comb begin
        lap_hold_d = lap_hold_q;
        snap_d     = snap_q;
        if (clear_p || state_d != RUN) begin
            lap_hold_d = 1'b0;
        end else if (lap_p && state_q == RUN) begin
            lap_hold_d = !lap_hold_q;
            if (!lap_hold_q) begin
                snap_d = live_time;
            end
        end
    end

    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            lap_hold_q <= 1'b0;
            snap_q     <= '0;
        end else begin
            lap_hold_q <= lap_hold_d;
            snap_q     <= snap_d;
        end
    end

    assign lap_hold = lap_hold_q;
    assign {min_t, min_o, sec_t, sec_o} = lap_hold_q ? snap_q : live_time;
`else
    assign min_t = live_min_t;
    assign min_o = live_min_o;
    assign sec_t = live_sec_t;
    assign sec_o = live_sec_o;
`endif

endmodule
